// File: rtl/bsg_tag_tx_pkg.sv
// Shared types and elaboration-time helpers for the bsg_tag serial writer.
package bsg_tag_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_HDR  = 3'd2,
        ST_PAY  = 3'd3,
        ST_GAP  = 3'd4
    } bsg_tag_tx_state_e;

    // Start bit + node id + data_not_reset + length field.
    function automatic int hdr_bits_f(input int els, input int max_w);
        return 1 + $clog2(els) + 1 + $clog2(max_w + 1);
    endfunction

    // Down-counter must hold the longest single-state bit run.
    function automatic int cnt_width_f(input int init_len, input int max_w,
                                       input int hdr, input int gap);
        int m;
        m = init_len + 1;
        if (max_w > m) m = max_w;
        if (hdr > m) m = hdr;
        if (gap > m) m = gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bsg_tag_tx_shifter.sv
// Load/shift-right register with a bits-remaining down-counter; bit 0 is the
// registered line value.
module bsg_tag_tx_shifter
    import bsg_tag_tx_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int cnt_width_p = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_load_data,
    input  logic [width_p-1:0]     i_data,
    input  logic                   i_load_cnt,
    input  logic [cnt_width_p-1:0] i_cnt,
    input  logic                   i_shift,
    output logic                   o_bit,
    output logic                   o_last,
    output logic [cnt_width_p-1:0] o_cnt
);

    logic [width_p-1:0]     r_sreg;
    logic [cnt_width_p-1:0] r_cnt;

    // Data register and counter; loads win over shifts, zeros fill from the top.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_load_data) begin
                r_sreg <= i_data;
            end else if (i_shift) begin
                r_sreg <= {1'b0, r_sreg[width_p-1:1]};
            end else begin
                r_sreg <= r_sreg;
            end
            if (i_load_cnt) begin
                r_cnt <= i_cnt;
            end else if (i_shift && (r_cnt != '0)) begin
                r_cnt <= r_cnt - cnt_width_p'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign o_bit  = r_sreg[0];
    assign o_last = (r_cnt == cnt_width_p'(1));
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag packet writer: serializes init preambles and tag packets LSB-first
// onto a single registered tag data line.
module bsg_tag_serial_tx
    import bsg_tag_tx_pkg::*;
#(
    parameter int els_p               = 16,
    parameter int max_payload_width_p = 16,
    parameter int init_len_p          = 32,
    parameter int gap_p               = 2,
    localparam int lg_els_lp          = $clog2(els_p),
    localparam int lg_width_lp        = $clog2(max_payload_width_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           init_i,
    input  logic                           v_i,
    input  logic [lg_els_lp-1:0]           node_id_i,
    input  logic                           data_not_reset_i,
    input  logic [lg_width_lp-1:0]         len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    output logic                           ready_o,
    output logic                           busy_o,
    output logic                           tag_data_o
);

    localparam int hdr_bits_lp  = hdr_bits_f(els_p, max_payload_width_p);
    localparam int sreg_w_lp    = hdr_bits_lp + max_payload_width_p;
    localparam int cnt_w_lp     = cnt_width_f(init_len_p, max_payload_width_p, hdr_bits_lp, gap_p);

    // Header layout depends on the node/length widths, so it is built here.
    typedef struct packed {
        logic [lg_width_lp-1:0] len;
        logic                   data_not_reset;
        logic [lg_els_lp-1:0]   node_id;
    } hdr_s;

    bsg_tag_tx_state_e r_state, w_state_next;
    logic [lg_width_lp-1:0]         r_len, w_len_sat;
    logic [max_payload_width_p-1:0] w_pay_mask;
    hdr_s                           w_hdr;
    logic [sreg_w_lp-1:0]           w_pkt, w_load_data_val;
    logic [cnt_w_lp-1:0]            w_load_cnt_val, w_cnt;
    logic w_load_data, w_load_cnt, w_shift, w_last, w_bit, w_accept;

    // Saturate the length and clear payload bits beyond it so the tail shifts out as 0.
    always_comb begin
        w_len_sat  = len_i;
        w_pay_mask = '0;
        if (int'(len_i) > max_payload_width_p) begin
            w_len_sat = lg_width_lp'(max_payload_width_p);
        end else begin
            w_len_sat = len_i;
        end
        for (int i = 0; i < max_payload_width_p; i++) begin
            w_pay_mask[i] = (i < int'(w_len_sat));
        end
        w_hdr.len            = w_len_sat;
        w_hdr.data_not_reset = data_not_reset_i;
        w_hdr.node_id        = node_id_i;
        w_pkt                = {payload_i & w_pay_mask, w_hdr, 1'b1};
    end

    assign w_accept = (r_state == ST_IDLE) && !init_i && v_i;

    // State register and latched (saturated) length for the header->payload decision.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_len <= w_len_sat;
            end else begin
                r_len <= r_len;
            end
        end
    end

    // Next-state and shifter sequencing.
    always_comb begin
        w_state_next    = r_state;
        w_load_data     = 1'b0;
        w_load_data_val = '0;
        w_load_cnt      = 1'b0;
        w_load_cnt_val  = '0;
        w_shift         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (init_i) begin
                    w_state_next    = ST_INIT;
                    w_load_data     = 1'b1;
                    w_load_data_val = '1;
                    w_load_cnt      = 1'b1;
                    w_load_cnt_val  = cnt_w_lp'(init_len_p + 1);
                end else if (v_i) begin
                    w_state_next    = ST_HDR;
                    w_load_data     = 1'b1;
                    w_load_data_val = w_pkt;
                    w_load_cnt      = 1'b1;
                    w_load_cnt_val  = cnt_w_lp'(hdr_bits_lp);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_INIT: begin
                w_shift = 1'b1;
                // The preamble is wider than the register; clear it for the closing 0.
                if (w_cnt == cnt_w_lp'(2)) begin
                    w_load_data     = 1'b1;
                    w_load_data_val = '0;
                end else begin
                    w_load_data = 1'b0;
                end
                if (w_last) begin
                    w_state_next   = ST_GAP;
                    w_load_cnt     = 1'b1;
                    w_load_cnt_val = cnt_w_lp'(gap_p);
                end else begin
                    w_state_next = ST_INIT;
                end
            end
            ST_HDR: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_load_cnt = 1'b1;
                    if (r_len == '0) begin
                        w_state_next   = ST_GAP;
                        w_load_cnt_val = cnt_w_lp'(gap_p);
                    end else begin
                        w_state_next   = ST_PAY;
                        w_load_cnt_val = cnt_w_lp'(r_len);
                    end
                end else begin
                    w_state_next = ST_HDR;
                end
            end
            ST_PAY: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_next   = ST_GAP;
                    w_load_cnt     = 1'b1;
                    w_load_cnt_val = cnt_w_lp'(gap_p);
                end else begin
                    w_state_next = ST_PAY;
                end
            end
            ST_GAP: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_GAP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    bsg_tag_tx_shifter #(
        .width_p    (sreg_w_lp),
        .cnt_width_p(cnt_w_lp)
    ) u_shifter (
        .i_clk      (clk_i),
        .i_reset_n  (reset_n_i),
        .i_load_data(w_load_data),
        .i_data     (w_load_data_val),
        .i_load_cnt (w_load_cnt),
        .i_cnt      (w_load_cnt_val),
        .i_shift    (w_shift),
        .o_bit      (w_bit),
        .o_last     (w_last),
        .o_cnt      (w_cnt)
    );

    assign tag_data_o = w_bit;
    assign ready_o    = (r_state == ST_IDLE) && reset_n_i;
    assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Directed and randomized bench for bsg_tag_serial_tx; expected line bits come
// from a packet-level model that lists the wire bits in a queue.
module tb_bsg_tag_serial_tx;

    localparam int ELS   = 4;
    localparam int MAXW  = 8;
    localparam int INITL = 8;
    localparam int GAP   = 2;
    localparam int LGE   = 2;
    localparam int LGW   = 4;

    logic            clk = 1'b0;
    logic            reset_n, init, v, dnr;
    logic [LGE-1:0]  id;
    logic [LGW-1:0]  len;
    logic [MAXW-1:0] pay;
    logic            ready, busy, tag_data;

    int n_assert = 0;
    int n_fail   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    bsg_tag_serial_tx #(
        .els_p              (ELS),
        .max_payload_width_p(MAXW),
        .init_len_p         (INITL),
        .gap_p              (GAP)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .init_i          (init),
        .v_i             (v),
        .node_id_i       (id),
        .data_not_reset_i(dnr),
        .len_i           (len),
        .payload_i       (pay),
        .ready_o         (ready),
        .busy_o          (busy),
        .tag_data_o      (tag_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wire order: start, id LSB-first, dnr, saturated len LSB-first, payload, gap zeros.
    function automatic void model_pkt(input int pid, input int pdnr, input int plen,
                                      input logic [MAXW-1:0] ppay);
        int l;
        l = (plen > MAXW) ? MAXW : plen;
        exp_q.push_back(1'b1);
        for (int i = 0; i < LGE; i++) exp_q.push_back(((pid >> i) & 1) != 0);
        exp_q.push_back((pdnr & 1) != 0);
        for (int i = 0; i < LGW; i++) exp_q.push_back(((l >> i) & 1) != 0);
        for (int i = 0; i < l; i++) exp_q.push_back(ppay[i]);
        for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
    endfunction

    function automatic void model_init();
        for (int i = 0; i < INITL; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
    endfunction

    task automatic expect_stream(input string tag);
        bit b;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check({tag, "_bit"}, 32'(tag_data), 32'(b));
            check({tag, "_ready_low"}, 32'(ready), 32'd0);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            step();
        end
        check({tag, "_ready_end"}, 32'(ready), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_idle_line"}, 32'(tag_data), 32'd0);
    endtask

    task automatic drive_fields(input int pid, input int pdnr, input int plen,
                                input logic [MAXW-1:0] ppay);
        id  = LGE'(pid);
        dnr = 1'(pdnr);
        len = LGW'(plen);
        pay = ppay;
    endtask

    task automatic send(input int pid, input int pdnr, input int plen,
                        input logic [MAXW-1:0] ppay, input string tag);
        check({tag, "_ready_acc"}, 32'(ready), 32'd1);
        drive_fields(pid, pdnr, plen, ppay);
        v = 1'b1;
        model_pkt(pid, pdnr, plen, ppay);
        step();
        v = 1'b0;
        drive_fields(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), MAXW'($urandom));
        expect_stream(tag);
    endtask

    initial begin
        int pid, pdnr, plen;
        logic [MAXW-1:0] ppay;
        string nm;

        reset_n = 1'b0; init = 1'b0; v = 1'b0;
        drive_fields(0, 0, 0, 8'h00);
        step(); step();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_line", 32'(tag_data), 32'd0);
        reset_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(ready), 32'd1);
        step();

        // Basic packet: 1,0,1,1,1,1,0,0,1,0,1 then 0,0, ready low 13 cycles.
        send(2, 1, 3, 8'h05, "basic");

        // Init with a coincident packet that must wait for the preamble.
        check("init_ready", 32'(ready), 32'd1);
        drive_fields(1, 1, 2, 8'h03);
        init = 1'b1; v = 1'b1;
        step();
        init = 1'b0;
        model_init();
        expect_stream("init");
        model_pkt(1, 1, 2, 8'h03);
        step();
        v = 1'b0;
        expect_stream("after_init");

        send(3, 0, 0, 8'hA5, "zero_len");
        send(1, 1, 15, 8'hFF, "saturate");

        // Reset during the second payload bit.
        check("rst_ready_acc", 32'(ready), 32'd1);
        ppay = MAXW'($urandom);
        drive_fields(1, 1, 4, ppay);
        v = 1'b1;
        model_pkt(1, 1, 4, ppay);
        step();
        v = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("rst_pkt_bit", 32'(tag_data), 32'(exp_q.pop_front()));
            if (k < 9) step();
        end
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        check("rst_ready_comb", 32'(ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_line", 32'(tag_data), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ready", 32'(ready), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(ready), 32'd1);
        step();
        send(2, 0, 5, 8'h1B, "post_rst");

        // Back-to-back: v_i held through packet A so B is taken at the first ready cycle.
        check("b2b_ready_a", 32'(ready), 32'd1);
        drive_fields(3, 1, 2, 8'h02);
        v = 1'b1;
        model_pkt(3, 1, 2, 8'h02);
        step();
        drive_fields(0, 1, 3, 8'h06);
        expect_stream("b2b_a");
        model_pkt(0, 1, 3, 8'h06);
        step();
        v = 1'b0;
        expect_stream("b2b_b");

        // Randomized packets and inits with 0..2 idle cycles between them.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                check("rnd_init_ready", 32'(ready), 32'd1);
                init = 1'b1;
                step();
                init = 1'b0;
                model_init();
                expect_stream("rnd_init");
            end else begin
                pid  = int'($urandom_range(0, 3));
                pdnr = int'($urandom_range(0, 1));
                plen = int'($urandom_range(0, 15));
                ppay = MAXW'($urandom);
                nm   = $sformatf("rnd%0d", n);
                send(pid, pdnr, plen, ppay, nm);
            end
            for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
                step();
                check("rnd_idle_line", 32'(tag_data), 32'd0);
                check("rnd_idle_ready", 32'(ready), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
